// File: rtl/uart_frame_decoder.sv
// UART line decoder: oversampled start/data/parity/stop recovery with a valid/ready
// output register carrying parity, framing and break status per character.
module uart_frame_decoder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned OVERSAMPLE  = 16
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       baud_i,
    input  logic       sin,
    input  logic       enable,
    input  logic [5:0] lcr,
    input  logic       rx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       parity_err,
    output logic       framing_err,
    output logic       break_det,
    output logic       overrun
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_TICK = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBrkWait
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_e                 state_q;
    logic [TW-1:0]          tick_q;
    logic [2:0]             bit_q;
    logic [7:0]             shift_q;
    logic                   par_err_q;
    logic                   par_zero_q;

    logic last_bit;
    logic exp_par;
    logic done;
    logic done_brk;
    logic unused_lcr;

    assign unused_lcr = lcr[2];

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sin};
        end
    end

    always_comb begin
        s        = sync_q[SYNC_STAGES-1];
        last_bit = (bit_q >= (3'd4 + {1'b0, lcr[1:0]}));
        exp_par  = lcr[5] ? ~lcr[4] : (^shift_q ^ ~lcr[4]);
        done     = enable && baud_i && (state_q == StStop) && (tick_q == LAST_TICK);
        // Break: every sampled bit of the frame, stop bit included, was low.
        done_brk = done && !s && (shift_q == 8'h00) && par_zero_q;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q    <= StIdle;
            tick_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
            par_zero_q <= 1'b1;
        end else if (!enable) begin
            state_q <= StIdle;
            tick_q  <= '0;
            bit_q   <= '0;
        end else if (baud_i) begin
            case (state_q)
                StIdle: begin
                    if (!s) begin
                        state_q <= StStart;
                        tick_q  <= '0;
                    end
                end
                StStart: begin
                    if (tick_q == HALF_TICK) begin
                        if (s) begin
                            state_q <= StIdle;
                        end else begin
                            state_q    <= StData;
                            tick_q     <= '0;
                            bit_q      <= '0;
                            shift_q    <= '0;
                            par_err_q  <= 1'b0;
                            par_zero_q <= 1'b1;
                        end
                    end else begin
                        tick_q <= tick_q + TW'(1);
                    end
                end
                StData: begin
                    tick_q <= tick_q + TW'(1);
                    if (tick_q == LAST_TICK) begin
                        shift_q[bit_q] <= s;
                        bit_q          <= bit_q + 3'd1;
                        // >= rather than == so a mid-frame lcr shrink cannot strand us here
                        if (last_bit) begin
                            state_q <= lcr[3] ? StParity : StStop;
                        end
                    end
                end
                StParity: begin
                    tick_q <= tick_q + TW'(1);
                    if (tick_q == LAST_TICK) begin
                        par_err_q <= (s != exp_par);
                        if (s) begin
                            par_zero_q <= 1'b0;
                        end
                        state_q <= StStop;
                    end
                end
                StStop: begin
                    tick_q <= tick_q + TW'(1);
                    if (tick_q == LAST_TICK) begin
                        state_q <= done_brk ? StBrkWait : StIdle;
                    end
                end
                StBrkWait: begin
                    if (s) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rx_valid    <= 1'b0;
            rx_data     <= '0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            break_det   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (!rx_valid || rx_ready) begin
                    rx_valid    <= 1'b1;
                    rx_data     <= shift_q;
                    parity_err  <= par_err_q;
                    framing_err <= !s;
                    break_det   <= done_brk;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed bench for uart_frame_decoder: frames are driven bit by bit on sin and the
// expected characters are queued, then compared as the DUT hands them out.
module tb_uart_frame_decoder;

    logic       PCLK = 1'b0;
    logic       PRESET = 1'b1;
    logic       baud_i = 1'b0;
    logic       sin = 1'b1;
    logic       enable = 1'b1;
    logic [5:0] lcr = 6'b000011;
    logic       rx_ready = 1'b1;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       parity_err;
    logic       framing_err;
    logic       break_det;
    logic       overrun;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       exp_e;
    int         tests = 0;
    int         fails = 0;
    int         ovr_cnt = 0;
    int         pop_cnt = 0;
    int         baud_n = 0;
    int         snap;
    logic       hold_v = 1'b0;
    logic [7:0] hold_d = 8'h00;

    uart_frame_decoder #(
        .SYNC_STAGES(2),
        .OVERSAMPLE (16)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .baud_i     (baud_i),
        .sin        (sin),
        .enable     (enable),
        .lcr        (lcr),
        .rx_ready   (rx_ready),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .parity_err (parity_err),
        .framing_err(framing_err),
        .break_det  (break_det),
        .overrun    (overrun)
    );

    initial forever #5 PCLK = ~PCLK;

    // One strobe every second PCLK cycle.
    initial forever begin
        @(posedge PCLK);
        #1;
        baud_n++;
        baud_i = (baud_n % 2 == 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard side: every accepted character is popped and compared.
    initial forever begin
        @(negedge PCLK);
        if (overrun === 1'b1) ovr_cnt++;
        if (PRESET) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v && rx_valid) check("hold_stable", {24'h0, rx_data}, {24'h0, hold_d});
            hold_v = rx_valid && !rx_ready;
            hold_d = rx_data;
            if (rx_valid && rx_ready) begin
                pop_cnt++;
                check("char_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    exp_e = exp_q.pop_front();
                    check("rx_data", {24'h0, rx_data}, {24'h0, exp_e.data});
                    check("parity_err", parity_err, exp_e.perr);
                    check("framing_err", framing_err, exp_e.ferr);
                    check("break_det", break_det, exp_e.brk);
                end
            end
        end
    end

    task automatic wait_strobe();
        do @(posedge PCLK); while (baud_i !== 1'b1);
    endtask

    task automatic do_abort(input int kind);
        if (kind == 1) begin
            PRESET = 1'b1;
            repeat (2) @(posedge PCLK);
            #2;
            check("abort_reset_valid", rx_valid, 1'b0);
            PRESET = 1'b0;
        end else begin
            enable = 1'b0;
            repeat (3) @(posedge PCLK);
            #2;
            enable = 1'b1;
        end
    endtask

    // frame[0] is the start bit; each bit held for 16 strobes.
    task automatic send_bits(input logic [15:0] frame, input int nb, input int ready_at,
                             input int abort_at, input int abort_kind);
        int k;
        k = 0;
        wait_strobe();
        #2;
        for (int b = 0; b < nb; b++) begin
            sin = frame[b];
            for (int j = 0; j < 16; j++) begin
                wait_strobe();
                k++;
                #2;
                if (k == ready_at) rx_ready = 1'b1;
                if (k == abort_at) begin
                    sin = 1'b1;
                    do_abort(abort_kind);
                    return;
                end
            end
        end
        sin = 1'b1;
    endtask

    function automatic logic [15:0] make_frame(input logic [7:0] d, input int nd,
                                               input logic pen, input logic pb);
        logic [15:0] f;
        int          idx;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < nd; i++) f[1+i] = d[i];
        idx = 1 + nd;
        if (pen) begin
            f[idx] = pb;
            idx++;
        end
        f[idx] = 1'b1;
        return f;
    endfunction

    task automatic send_char(input logic [7:0] d, input int nd, input logic pen,
                             input logic pb, input int ready_at);
        send_bits(make_frame(d, nd, pen, pb), 2 + nd + int'(pen), ready_at, 0, 0);
    endtask

    task automatic push(input logic [7:0] d, input logic pe, input logic fe, input logic bk);
        exp_t e;
        e = '{data: d, perr: pe, ferr: fe, brk: bk};
        exp_q.push_back(e);
    endtask

    task automatic idle_strobes(input int n);
        repeat (n) wait_strobe();
        #2;
    endtask

    initial begin
        repeat (3) @(posedge PCLK);
        #2;
        check("reset_valid", rx_valid, 1'b0);
        check("reset_data", {24'h0, rx_data}, 32'h0);
        check("reset_perr", parity_err, 1'b0);
        check("reset_ferr", framing_err, 1'b0);
        check("reset_brk", break_det, 1'b0);
        check("reset_overrun", overrun, 1'b0);
        PRESET = 1'b0;
        idle_strobes(8);

        // 8N1
        push(8'hA5, 1'b0, 1'b0, 1'b0);
        send_char(8'hA5, 8, 1'b0, 1'b0, 0);

        // 7E1: 0x35 has four ones, correct even parity bit is 0
        lcr = 6'b011010;
        idle_strobes(4);
        push(8'h35, 1'b1, 1'b0, 1'b0);
        send_char(8'h35, 7, 1'b1, 1'b1, 0);
        push(8'h35, 1'b0, 1'b0, 1'b0);
        send_char(8'h35, 7, 1'b1, 1'b0, 0);

        // Break on 8N1: 12 bit times low
        lcr = 6'b000011;
        idle_strobes(4);
        push(8'h00, 1'b0, 1'b1, 1'b1);
        send_bits(16'h0000, 12, 0, 0, 0);
        idle_strobes(48);
        check("break_delivered", exp_q.size(), 0);
        check("break_single_char", pop_cnt, 4);

        // Glitch of 4 strobes must be rejected
        snap = pop_cnt;
        wait_strobe();
        #2;
        sin = 1'b0;
        idle_strobes(4);
        sin = 1'b1;
        idle_strobes(32);
        check("glitch_no_char", pop_cnt, snap);
        push(8'h5A, 1'b0, 1'b0, 1'b0);
        send_char(8'h5A, 8, 1'b0, 1'b0, 0);

        // Overrun: 0x11 held, 0x22 dropped, then 0x33 completes on the pop cycle
        rx_ready = 1'b0;
        snap = ovr_cnt;
        push(8'h11, 1'b0, 1'b0, 1'b0);
        send_char(8'h11, 8, 1'b0, 1'b0, 0);
        check("no_overrun_first", ovr_cnt, snap);
        send_char(8'h22, 8, 1'b0, 1'b0, 0);
        check("overrun_once", ovr_cnt, snap + 1);
        check("overrun_kept_old", {24'h0, rx_data}, 32'h11);
        check("overrun_valid_held", rx_valid, 1'b1);
        push(8'h33, 1'b0, 1'b0, 1'b0);
        send_char(8'h33, 8, 1'b0, 1'b0, 153);
        check("simultaneous_no_overrun", ovr_cnt, snap + 1);
        idle_strobes(8);

        // Reset during data bit 3 of 0xFF
        snap = pop_cnt;
        send_bits(make_frame(8'hFF, 8, 1'b0, 1'b0), 10, 0, 72, 1);
        idle_strobes(32);
        check("reset_abort_no_char", pop_cnt, snap);
        push(8'h0F, 1'b0, 1'b0, 1'b0);
        send_char(8'h0F, 8, 1'b0, 1'b0, 0);

        // Enable drop during data bit 3 of 0xFF
        snap = pop_cnt;
        send_bits(make_frame(8'hFF, 8, 1'b0, 1'b0), 10, 0, 72, 2);
        idle_strobes(32);
        check("enable_abort_no_char", pop_cnt, snap);
        push(8'h0F, 1'b0, 1'b0, 1'b0);
        send_char(8'h0F, 8, 1'b0, 1'b0, 0);

        idle_strobes(64);
        check("all_delivered", exp_q.size(), 0);
        check("total_overruns", ovr_cnt, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_frame_decoder.md
Name: uart_frame_decoder

Overview:
- Serial-side consumer of the UART transmit line (TXD) and the 16x baud strobe (baud_o).
- Reconstructs each transmitted character from the line using the same line-control encoding the UART uses.
- Presents characters on a valid/ready output with per-character parity, framing and break status.
- Used as an on-chip checker and as the receive front-end of a peer device.

Parameters:
SYNC_STAGES, 2, number of flops in the serial-input synchroniser (>=2).
OVERSAMPLE, 16, baud strobes per bit time; mid-bit sample taken on strobe count OVERSAMPLE/2-1.

Ports:
PCLK  input  1  system clock, all state on rising edge
PRESET  input  1  asynchronous active-high reset
baud_i  input  1  oversample strobe, one PCLK wide, OVERSAMPLE per bit
sin  input  1  serial line (TXD), idle high
enable  input  1  decoder enable; low forces IDLE
lcr  input  6  [1:0] word length-5, [3] parity enable, [4] even parity, [5] stick parity; [2] unused
rx_ready  input  1  consumer accepts character
rx_valid  output  1  character held in output register
rx_data  output  8  character, LSB = first data bit, bits above word length zero
parity_err  output  1  status of held character
framing_err  output  1  status of held character
break_det  output  1  status of held character
overrun  output  1  one-cycle pulse, completed character discarded

Behaviour:
- Clock and reset: one clock domain, PCLK; reset is asynchronous and active-high on PRESET.
- Reset values:
  - Synchroniser flops 1.
  - State IDLE, counters 0.
  - rx_valid, rx_data, all error flags and overrun 0.
- Input path: sin passes through SYNC_STAGES flops. All decisions use the synchronised value (s).
- All state and counter advances happen only on cycles with baud_i=1, except the output handshake.
- IDLE:
  - s=0 on a strobe -> START, tick counter cleared.
- START:
  - At tick OVERSAMPLE/2-1: s=1 -> IDLE (glitch rejected, nothing output); s=0 -> DATA, tick counter cleared, bit counter 0.
- DATA:
  - Sample s every OVERSAMPLE ticks; shift in LSB first.
  - After 5+lcr[1:0] bits -> PARITY if lcr[3], else STOP.
- PARITY:
  - Sample one bit. Expected value:
    - lcr[5]=0: XOR of data bits XOR ~lcr[4].
    - lcr[5]=1: ~lcr[4].
  - Mismatch sets the parity error for this character.
- STOP:
  - Sample one bit; s=0 sets framing error.
  - Only the first stop bit is checked.
  - Character completes on this sample strobe.
- Break:
  - Condition: all data bits, parity bit (if enabled) and stop bit sampled 0.
  - break_det=1 with framing_err=1 and rx_data=0.
  - Then -> BRK_WAIT until s=1 on a strobe, then -> IDLE.
- After a normal STOP: -> IDLE immediately, so a start bit may begin on the next strobe.
- Output register:
  - On completion (cycle C), rx_valid, rx_data and flags load at edge C+1.
  - Contents stay stable while rx_valid=1 && rx_ready=0.
  - rx_valid && rx_ready pops; rx_valid falls next edge unless a new character loads in the same cycle.
- Simultaneous pop and completion: new character loads, rx_valid stays 1, no overrun.
- Completion while rx_valid=1 && rx_ready=0: new character dropped, old one kept, overrun pulses high for exactly one cycle (C+1).
- enable=0:
  - Next edge forces IDLE and clears counters; in-flight character discarded without flags.
  - Output register and handshake unaffected.
- PRESET mid-frame: everything returns to reset values immediately; no partial character is ever output.
- lcr changes are sampled continuously. Software changes lcr only while the line is idle; mid-frame changes give undefined data but never lock up the FSM (every state exits within 13 bit times).
- Counter widths:
  - Tick counter: clog2(OVERSAMPLE) bits, wraps naturally.
  - Bit counter: 3 bits.

Test Plan:
- lcr=6'b000011 (8N1), send 0xA5 at 16 strobes/bit, rx_ready=1 -> rx_valid one cycle, rx_data=0xA5, all flags 0.
- lcr=6'b011010 (7E1), send 0x35 with wrong parity bit 1 -> rx_data=0x35, parity_err=1, framing_err=0; repeat with parity 0 -> parity_err=0.
- 8N1, hold sin low for 12 bit times, then high -> one character: rx_data=0x00, break_det=1, framing_err=1. No further character until a new start bit arrives after line returns high.
- 8N1, rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun pulses once at completion of 0x22. Raise rx_ready on the same cycle as a third character 0x33 completes -> 0x33 loads, no overrun.
- Low pulse on sin of 4 strobes (shorter than half a bit) -> returns to IDLE, rx_valid never asserts; a following 0x5A decodes correctly.
- PRESET high during DATA bit 3 of 0xFF, release, send 0x0F -> only 0x0F output, flags 0. Repeat with enable dropped mid-frame -> same result.
